// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM register file.
package pwm_pkg;

    // Word indices of the global registers
    localparam int unsigned CTRL_IDX    = 0;
    localparam int unsigned STATUS_IDX  = 1;
    localparam int unsigned IRQ_EN_IDX  = 2;
    localparam int unsigned VERSION_IDX = 3;
    // First per-channel word; channel i owns PERIOD at CH_BASE+2i and DUTY at CH_BASE+2i+1
    localparam int unsigned CH_BASE     = 4;

    // CTRL bit positions
    localparam int unsigned CTRL_GEN_BIT = 16;
    localparam int unsigned CTRL_UPD_BIT = 17;

    localparam logic [31:0] VERSION_VAL = 32'h0001_0000;

    typedef enum logic [1:0] {
        RdIdle,
        RdAddr,
        RdValid
    } rd_state_e;

    // Word index of the PERIOD staging register for a channel
    function automatic int unsigned ch_period_idx(input int unsigned ch);
        return CH_BASE + 2 * ch;
    endfunction

endpackage

// File: rtl/pwm_ch_shadow.sv
// Per-channel staging/active period and duty with deferred update.
module pwm_ch_shadow #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic                 period_we_i,
    input  logic                 duty_we_i,
    input  logic [CNT_WIDTH-1:0] wdata_i,
    input  logic                 upd_i,
    input  logic                 period_end_i,
    input  logic                 ch_en_i,
    output logic [CNT_WIDTH-1:0] stg_period_o,
    output logic [CNT_WIDTH-1:0] stg_duty_o,
    output logic [CNT_WIDTH-1:0] period_o,
    output logic [CNT_WIDTH-1:0] duty_o
);

    logic [CNT_WIDTH-1:0] stg_period_q, stg_period_d;
    logic [CNT_WIDTH-1:0] stg_duty_q, stg_duty_d;
    logic [CNT_WIDTH-1:0] act_period_q, act_period_d;
    logic [CNT_WIDTH-1:0] act_duty_q, act_duty_d;
    logic                 pending_q, pending_d;
    logic                 copy;

    // Copy only once pending is registered, so a wrap coincident with UPD is ignored;
    // a disabled channel has no wraps and copies straight away. The copy reads the
    // registered staging value, so a same-cycle staging write lands afterwards.
    always_comb begin
        copy         = pending_q & (period_end_i | ~ch_en_i);
        stg_period_d = period_we_i ? wdata_i : stg_period_q;
        stg_duty_d   = duty_we_i ? wdata_i : stg_duty_q;
        act_period_d = copy ? stg_period_q : act_period_q;
        act_duty_d   = copy ? stg_duty_q : act_duty_q;
        pending_d    = upd_i | (pending_q & ~copy);
    end

    // State registers
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            stg_period_q <= '0;
            stg_duty_q   <= '0;
            act_period_q <= '0;
            act_duty_q   <= '0;
            pending_q    <= 1'b0;
        end else begin
            stg_period_q <= stg_period_d;
            stg_duty_q   <= stg_duty_d;
            act_period_q <= act_period_d;
            act_duty_q   <= act_duty_d;
            pending_q    <= pending_d;
        end
    end

    assign stg_period_o = stg_period_q;
    assign stg_duty_o   = stg_duty_q;
    assign period_o     = act_period_q;
    assign duty_o       = act_duty_q;

endmodule

// File: rtl/pwm_regs.sv
// Register file for the multi-channel PWM generator.
module pwm_regs
    import pwm_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    input  logic                        write_en,
    input  logic [ADDR_WIDTH-1:0]       write_addr,
    input  logic [DATA_WIDTH-1:0]       write_data,
    input  logic                        read_en,
    input  logic [ADDR_WIDTH-1:0]       read_addr,
    output logic [DATA_WIDTH-1:0]       read_data,
    output logic                        read_valid,
    input  logic [NUM_CH-1:0]           period_end,
    output logic [NUM_CH-1:0]           ch_en_o,
    output logic [NUM_CH*CNT_WIDTH-1:0] period_o,
    output logic [NUM_CH*CNT_WIDTH-1:0] duty_o,
    output logic                        irq
);

    logic [NUM_CH-1:0]     ch_en_q, ch_en_d;
    logic                  global_en_q, global_en_d;
    logic [NUM_CH-1:0]     status_q, status_d;
    logic [NUM_CH-1:0]     irq_en_q, irq_en_d;
    logic                  irq_q, irq_d;
    rd_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_mux;
    logic                  rvalid_q, rvalid_d;

    logic                  wr_ctrl, wr_status, wr_irq_en, upd;
    logic [NUM_CH-1:0]     period_we, duty_we;
    logic [CNT_WIDTH-1:0]  stg_period [NUM_CH];
    logic [CNT_WIDTH-1:0]  stg_duty [NUM_CH];
    logic [CNT_WIDTH-1:0]  act_period [NUM_CH];
    logic [CNT_WIDTH-1:0]  act_duty [NUM_CH];

    // Upper data bits not covered by any field are intentionally dropped
    logic unused_wdata;
    assign unused_wdata = ^write_data;

    // Write address decode
    always_comb begin
        wr_ctrl   = write_en && (write_addr == ADDR_WIDTH'(CTRL_IDX));
        wr_status = write_en && (write_addr == ADDR_WIDTH'(STATUS_IDX));
        wr_irq_en = write_en && (write_addr == ADDR_WIDTH'(IRQ_EN_IDX));
        upd       = wr_ctrl && write_data[CTRL_UPD_BIT];
        for (int i = 0; i < NUM_CH; i++) begin
            period_we[i] = write_en && (write_addr == ADDR_WIDTH'(ch_period_idx(i)));
            duty_we[i]   = write_en && (write_addr == ADDR_WIDTH'(ch_period_idx(i) + 1));
        end
    end

    // Next-state for global registers; status set beats a same-cycle W1C
    always_comb begin
        ch_en_d     = wr_ctrl ? write_data[NUM_CH-1:0] : ch_en_q;
        global_en_d = wr_ctrl ? write_data[CTRL_GEN_BIT] : global_en_q;
        irq_en_d    = wr_irq_en ? write_data[NUM_CH-1:0] : irq_en_q;
        status_d    = (status_q & ~(wr_status ? write_data[NUM_CH-1:0] : '0)) | period_end;
        irq_d       = |(status_q & irq_en_q);
    end

    // Read data mux over the registered state, so a same-cycle write is not visible
    always_comb begin
        rd_mux = '0;
        if (read_addr == ADDR_WIDTH'(CTRL_IDX)) begin
            rd_mux[NUM_CH-1:0]   = ch_en_q;
            rd_mux[CTRL_GEN_BIT] = global_en_q;
        end else if (read_addr == ADDR_WIDTH'(STATUS_IDX)) begin
            rd_mux[NUM_CH-1:0] = status_q;
        end else if (read_addr == ADDR_WIDTH'(IRQ_EN_IDX)) begin
            rd_mux[NUM_CH-1:0] = irq_en_q;
        end else if (read_addr == ADDR_WIDTH'(VERSION_IDX)) begin
            rd_mux = DATA_WIDTH'(VERSION_VAL);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (read_addr == ADDR_WIDTH'(ch_period_idx(i))) begin
                rd_mux = DATA_WIDTH'(stg_period[i]);
            end
            if (read_addr == ADDR_WIDTH'(ch_period_idx(i) + 1)) begin
                rd_mux = DATA_WIDTH'(stg_duty[i]);
            end
        end
    end

    // Read pipeline: read_en restarts at RdAddr, address decoded one cycle later
    always_comb begin
        state_d  = state_q;
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        case (state_q)
            RdIdle, RdValid: begin
                if (read_en) begin
                    state_d  = RdAddr;
                    rvalid_d = 1'b0;
                end
            end
            RdAddr: begin
                if (read_en) begin
                    rvalid_d = 1'b0;
                end else begin
                    state_d  = RdValid;
                    rdata_d  = rd_mux;
                    rvalid_d = 1'b1;
                end
            end
            default: state_d = RdIdle;
        endcase
    end

    // Global register and read pipeline state
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ch_en_q     <= '0;
            global_en_q <= 1'b0;
            status_q    <= '0;
            irq_en_q    <= '0;
            irq_q       <= 1'b0;
            state_q     <= RdIdle;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            ch_en_q     <= ch_en_d;
            global_en_q <= global_en_d;
            status_q    <= status_d;
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
            state_q     <= state_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_ch_shadow #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_shadow (
            .ACLK        (ACLK),
            .ARESETn     (ARESETn),
            .period_we_i (period_we[g]),
            .duty_we_i   (duty_we[g]),
            .wdata_i     (write_data[CNT_WIDTH-1:0]),
            .upd_i       (upd),
            .period_end_i(period_end[g]),
            .ch_en_i     (ch_en_o[g]),
            .stg_period_o(stg_period[g]),
            .stg_duty_o  (stg_duty[g]),
            .period_o    (act_period[g]),
            .duty_o      (act_duty[g])
        );
    end

    // Pack active values for the PWM core
    always_comb begin
        period_o = '0;
        duty_o   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            period_o[i*CNT_WIDTH +: CNT_WIDTH] = act_period[i];
            duty_o[i*CNT_WIDTH +: CNT_WIDTH]   = act_duty[i];
        end
    end

    assign ch_en_o    = ch_en_q & {NUM_CH{global_en_q}};
    assign read_data  = rdata_q;
    assign read_valid = rvalid_q;
    assign irq        = irq_q;

endmodule

// File: doc/pwm_regs.md
Name: pwm_regs

Overview:
- Register file for the multi-channel PWM generator. Sits directly downstream of the AXI4-Lite slave and consumes its decoded single-beat write/read interface.
- Holds global and per-channel control, period and duty settings. Double-buffers period/duty so the PWM core only sees new values at a period boundary.
- Collects sticky period-done status and drives one level interrupt.

Parameters:
- ADDR_WIDTH, 5, word-index address width; must match the AXI slave.
- DATA_WIDTH, 32, register data width.
- NUM_CH, 4, number of PWM channels, 1..14.
- CNT_WIDTH, 16, width of period/duty counters, at most 32.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  reset, asynchronous, active-low.
- write_en  in  1  write strobe; may stay high several consecutive cycles for one transaction.
- write_addr  in  ADDR_WIDTH  word index of the write.
- write_data  in  DATA_WIDTH  write data.
- read_en  in  1  one-cycle pulse, asserted in the cycle the read address is accepted.
- read_addr  in  ADDR_WIDTH  read word index; valid from the cycle after read_en.
- read_data  out  DATA_WIDTH  registered read data.
- read_valid  out  1  read_data valid.
- period_end  in  NUM_CH  per-channel one-cycle pulse from the PWM core at each counter wrap.
- ch_en_o  out  NUM_CH  effective enable (ch_en AND global_en).
- period_o  out  NUM_CH*CNT_WIDTH  active periods; channel i occupies bits [i*CNT_WIDTH +: CNT_WIDTH].
- duty_o  out  NUM_CH*CNT_WIDTH  active duties, same packing as period_o.
- irq  out  1  registered OR of (STATUS & IRQ_EN).

Behaviour:
- Word map:
  - 0 CTRL: [NUM_CH-1:0] ch_en; [16] global_en; [17] UPD, write-1 strobe, always reads 0.
  - 1 STATUS: [NUM_CH-1:0] period_done, sticky, write-1-to-clear.
  - 2 IRQ_EN: [NUM_CH-1:0].
  - 3 VERSION: read-only 0x0001_0000.
  - 4+2i: PERIOD[i] staging.
  - 5+2i: DUTY[i] staging.
- Unmapped words: writes ignored, reads return 0. Bits above the field width: ignored on write, read as 0.
- Write: applied on every ACLK edge where write_en=1. All writes are idempotent, so a repeated strobe has no extra effect.
- Read pipeline, states IDLE -> ADDR -> VALID:
  - read_en in cycle N: read_valid drops to 0 at edge N+1.
  - read_addr is decoded during cycle N+1. read_data and read_valid=1 are registered at edge N+2.
  - read_valid and read_data then hold until the next read_en.
  - A new read_en while in ADDR restarts the sequence from ADDR.
  - Reads have no side effects.
- Read/write to the same word in the same cycle: the read returns the value before the write.
- Shadowing, per channel:
  - Staging PERIOD/DUTY are written by software. Active copies drive period_o/duty_o.
  - Writing UPD=1 sets upd_pending[i] for all i.
  - If ch_en_o[i]=1, the copy staging->active happens on the next period_end[i] strictly after the UPD write, and clears pending. A period_end in the same cycle as the UPD write does not trigger the copy.
  - If ch_en_o[i]=0, the copy happens on the cycle after pending is set.
  - A staging write in the same cycle as a copy: the copy takes the old staging value.
- STATUS: period_end[i] sets period_done[i]. A simultaneous set and W1C leaves the bit set (set wins).
- irq: registered, so it lags a status/enable change by 1 cycle.
- Arithmetic: duty > period is stored unmodified (the core saturates at 100%). period=0 is legal and stored as-is.
- Reset values: all registers, active copies and pending bits = 0. read_data=0, read_valid=0, irq=0, ch_en_o=0, period_o=0, duty_o=0.
- Reset mid-read: the sequence is abandoned and read_valid=0.

Decomposition:
- Package pwm_pkg: word indices (CTRL, STATUS, IRQ_EN, VERSION, CH_BASE), CTRL bit positions, VERSION constant, read-state enum.
- Sub-module pwm_ch_shadow, one instance per channel: staging/active period and duty, upd_pending, copy logic.

Test Plan:
- Reset, then read word 3 -> read_valid rises exactly 2 cycles after read_en; read_data=0x0001_0000; all outputs 0.
- Write PERIOD0=1000, DUTY0=250, CTRL=0x1_0001, then UPD. Channel enabled -> period_o[15:0] stays 0 until the first period_end[0] after UPD, then equals 1000 with duty 250.
- Channel 1 disabled, PERIOD1=0x1234, UPD -> active period updates 1 cycle after pending is set, with no period_end needed.
- IRQ_EN=0x2, pulse period_end[1] -> STATUS=0x2 and irq=1 one cycle later. Write STATUS=0x2 in the same cycle as another period_end[1] -> bit stays set. W1C alone -> irq drops.
- Hold write_en 3 cycles with STATUS W1C, and separately with UPD -> same result as a single-cycle strobe. Write 0xFFFF_FFFF to PERIOD2 -> reads back 0x0000_FFFF.
- Read unmapped word 31 -> 0. Assert ARESETn low in the ADDR state -> read_valid=0 and all registers 0.
